// File: rtl/frame_capture_pkg.sv
// Shared types and register map for the VGA window capture controller.
package frame_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] ADDR_CTRL   = 8'd0;
  localparam logic [7:0] ADDR_STATUS = 8'd1;
  localparam logic [7:0] ADDR_WIN_X  = 8'd2;
  localparam logic [7:0] ADDR_WIN_Y  = 8'd3;
  localparam logic [7:0] ADDR_DATA   = 8'd4;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_LEVEL_LSB = 16;

  localparam int unsigned WIN_LEN_LSB = 16;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO holding captured pixel words; flush empties it in one cycle.
module pixel_fifo #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, empty_q;
  logic              do_push_c, do_pop_c;

  assign do_push_c = push_i & ~full_q & ~flush_i;
  assign do_pop_c  = pop_i & ~empty_q & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Flags are registered from the next level so they line up with level_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_W'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Avalon-MM controlled capture of one rectangular window of a VGA frame into a pixel FIFO.
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned COORD_W    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        pix_en,
  output logic        irq
);

  localparam int unsigned CNT_W = 2 * COORD_W;
  localparam int unsigned CMP_W = COORD_W + 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q, state_d;
  logic               wr_c, rd_c, ctrl_wr_c, start_c, abort_c, busy_c;
  logic               done_q, done_d, ovf_q, ovf_d, irq_en_q, irq_en_d;
  logic [COORD_W-1:0] x0_q, x0_d, w_q, w_d, y0_q, y0_d, h_q, h_d;
  logic [CNT_W-1:0]   count_q, count_d, area_c;
  logic               hs_q, hs_qq, vs_q, vs_qq, hs_fall_c, vs_fall_c;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               line_pix_q, line_pix_d;
  logic               in_win_c, hit_c, last_c, push_c, pop_c, flush_c;
  logic               fifo_full, fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [31:0]        fifo_head, readdata_d;
  logic               unused_wd;

  assign unused_wd = ^writedata;

  assign wr_c      = chipselect & write;
  assign rd_c      = chipselect & read;
  assign ctrl_wr_c = wr_c && (address == ADDR_CTRL);
  assign abort_c   = ctrl_wr_c & writedata[CTRL_ABORT];
  assign start_c   = ctrl_wr_c & writedata[CTRL_START] & ~writedata[CTRL_ABORT];
  assign busy_c    = (state_q == ARM) || (state_q == CAPTURE);
  assign area_c    = CNT_W'(w_q) * CNT_W'(h_q);
  assign hs_fall_c = hs_qq & ~hs_q;
  assign vs_fall_c = vs_qq & ~vs_q;

  // Zero-extended bounds so x0+w never wraps around the coordinate width.
  assign in_win_c = (CMP_W'(x_q) >= CMP_W'(x0_q)) && (CMP_W'(x_q) < CMP_W'(x0_q) + CMP_W'(w_q)) &&
                    (CMP_W'(y_q) >= CMP_W'(y0_q)) && (CMP_W'(y_q) < CMP_W'(y0_q) + CMP_W'(h_q));
  assign hit_c    = (state_q == CAPTURE) & pix_en & in_win_c & ~abort_c;
  assign last_c   = hit_c && ((count_q + CNT_W'(1)) == area_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_c) state_d = (area_c == '0) ? DONE : ARM;
      ARM: begin
        if (abort_c)        state_d = IDLE;
        else if (vs_fall_c) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (abort_c)     state_d = IDLE;
        else if (last_c) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags, in-window counting and FIFO control follow the current state.
  always_comb begin
    done_d   = done_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    irq_en_d = irq_en_q;
    flush_c  = 1'b0;
    push_c   = 1'b0;
    if (ctrl_wr_c) irq_en_d = writedata[CTRL_IRQ_EN];
    case (state_q)
      IDLE, DONE: begin
        if (start_c) begin
          done_d  = (area_c == '0);
          ovf_d   = 1'b0;
          count_d = '0;
          flush_c = 1'b1;
        end
      end
      ARM, CAPTURE: begin
        if (abort_c) begin
          done_d  = 1'b0;
          flush_c = 1'b1;
        end else if (hit_c) begin
          count_d = count_q + CNT_W'(1);
          push_c  = ~fifo_full;
          if (fifo_full) ovf_d = 1'b1;
          if (last_c)    done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    x0_d = x0_q;
    w_d  = w_q;
    y0_d = y0_q;
    h_d  = h_q;
    if (wr_c && !busy_c) begin
      if (address == ADDR_WIN_X) begin
        x0_d = writedata[COORD_W-1:0];
        w_d  = writedata[WIN_LEN_LSB +: COORD_W];
      end
      if (address == ADDR_WIN_Y) begin
        y0_d = writedata[COORD_W-1:0];
        h_d  = writedata[WIN_LEN_LSB +: COORD_W];
      end
    end
  end

  // A line only advances y if it actually carried pixels (skips blank lines after VSYNC).
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    line_pix_d = line_pix_q;
    if (vs_fall_c) begin
      x_d        = '0;
      y_d        = '0;
      line_pix_d = 1'b0;
    end else if (hs_fall_c) begin
      x_d        = '0;
      y_d        = y_q + COORD_W'(line_pix_q);
      line_pix_d = 1'b0;
    end else if (pix_en) begin
      x_d        = x_q + COORD_W'(1);
      line_pix_d = 1'b1;
    end
  end

  always_comb begin
    readdata_d = readdata;
    pop_c      = 1'b0;
    if (rd_c) begin
      readdata_d = '0;
      case (address)
        ADDR_STATUS: begin
          readdata_d[STAT_BUSY]              = busy_c;
          readdata_d[STAT_DONE]              = done_q;
          readdata_d[STAT_OVF]               = ovf_q;
          readdata_d[STAT_LEVEL_LSB +: 16]   = 16'(fifo_level);
        end
        ADDR_WIN_X: begin
          readdata_d[COORD_W-1:0]            = x0_q;
          readdata_d[WIN_LEN_LSB +: COORD_W] = w_q;
        end
        ADDR_WIN_Y: begin
          readdata_d[COORD_W-1:0]            = y0_q;
          readdata_d[WIN_LEN_LSB +: COORD_W] = h_q;
        end
        ADDR_DATA: begin
          if (!fifo_empty) begin
            readdata_d = fifo_head;
            pop_c      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      count_q    <= '0;
      x0_q       <= '0;
      w_q        <= '0;
      y0_q       <= '0;
      h_q        <= '0;
      hs_q       <= 1'b1;
      hs_qq      <= 1'b1;
      vs_q       <= 1'b1;
      vs_qq      <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      line_pix_q <= 1'b0;
      readdata   <= '0;
    end else begin
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      count_q    <= count_d;
      x0_q       <= x0_d;
      w_q        <= w_d;
      y0_q       <= y0_d;
      h_q        <= h_d;
      hs_q       <= HSYNC;
      hs_qq      <= hs_q;
      vs_q       <= VSYNC;
      vs_qq      <= vs_q;
      x_q        <= x_d;
      y_q        <= y_d;
      line_pix_q <= line_pix_d;
      readdata   <= readdata_d;
    end
  end

  assign irq = done_q & irq_en_q;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_c),
    .push_i  (push_c),
    .wdata_i ({VGA_R, VGA_G, VGA_B, 8'd0}),
    .pop_i   (pop_c),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule
